// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: prescaler, tick, lap hold and digit-chain reset.
// Optional overflow autostop is built when STOPWATCH_AUTOSTOP_EN is defined.
module stopwatch_ctrl #(
  parameter int PRESCALE = 1000000,
  parameter int CNT_W    = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  input  logic       chain_cout,
  output logic       tick,
  output logic       chain_reset,
  output logic       hold,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  state_t           cur;
  state_t           nxt;
  logic [CNT_W-1:0] presc;
  logic [CNT_W-1:0] presc_nxt;
  logic             after_rst;
  logic             counting;
  logic             wrap;
  logic             stop_req;
  logic             clr_act;

  assign counting = (cur == RUN) || (cur == LAP);
  assign wrap     = counting && (presc == LAST);
  assign clr_act  = (cur == PAUSE) && btn_clr;
  assign state    = cur;

`ifdef STOPWATCH_AUTOSTOP_EN
  assign stop_req = counting & chain_cout;
`else
  // Chain overflow wraps the digits naturally; carry is not acted on.
  assign stop_req = chain_cout & 1'b0;
`endif

  // Next-state decode; overflow stop and start/stop share the PAUSE target.
  always_comb begin
    nxt = cur;
    unique case (cur)
      IDLE: begin
        if (btn_ss) nxt = RUN;
      end
      RUN: begin
        if (stop_req || btn_ss) nxt = PAUSE;
        else if (btn_lap)       nxt = LAP;
      end
      LAP: begin
        if (stop_req || btn_ss) nxt = PAUSE;
        else if (btn_lap)       nxt = RUN;
      end
      PAUSE: begin
        if (btn_clr)     nxt = IDLE;
        else if (btn_ss) nxt = RUN;
      end
      default: nxt = IDLE;
    endcase
  end

  // Prescaler counts while running, freezes in PAUSE, sits at 0 otherwise.
  always_comb begin
    presc_nxt = '0;
    if (counting) begin
      presc_nxt = wrap ? '0 : presc + CNT_W'(1);
    end else if ((cur == PAUSE) && !btn_clr) begin
      presc_nxt = presc;
    end
  end

  // All state and outputs are registered; reset dominates every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur         <= IDLE;
      presc       <= '0;
      tick        <= 1'b0;
      hold        <= 1'b0;
      chain_reset <= 1'b1;
      after_rst   <= 1'b1;
    end else begin
      cur         <= nxt;
      presc       <= presc_nxt;
      tick        <= wrap;
      hold        <= (nxt == LAP);
      chain_reset <= after_rst | clr_act;
      after_rst   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl at PRESCALE = 4.
// Stimulus pushes per-cycle expectations; a monitor pops and compares.
module tb_stopwatch_ctrl;

  logic       clk;
  logic       reset;
  logic       btn_ss;
  logic       btn_lap;
  logic       btn_clr;
  logic       chain_cout;
  logic       tick;
  logic       chain_reset;
  logic       hold;
  logic [1:0] state;

  typedef struct packed {
    logic [1:0] st;
    logic       tk;
    logic       hd;
    logic       cr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;

  stopwatch_ctrl #(.PRESCALE(4), .CNT_W(20)) dut (
    .clk(clk),
    .reset(reset),
    .btn_ss(btn_ss),
    .btn_lap(btn_lap),
    .btn_clr(btn_clr),
    .chain_cout(chain_cout),
    .tick(tick),
    .chain_reset(chain_reset),
    .hold(hold),
    .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: every cycle is an output beat; compare against queue head.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc_no++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("FAIL state cyc=%0d got=%b want=%b",
                 cyc_no, state, e.st);
      end
      checks++;
      if (tick !== e.tk) begin
        errors++;
        $display("FAIL tick cyc=%0d got=%b want=%b",
                 cyc_no, tick, e.tk);
      end
      checks++;
      if (hold !== e.hd) begin
        errors++;
        $display("FAIL hold cyc=%0d got=%b want=%b",
                 cyc_no, hold, e.hd);
      end
      checks++;
      if (chain_reset !== e.cr) begin
        errors++;
        $display("FAIL chain_reset cyc=%0d got=%b want=%b",
                 cyc_no, chain_reset, e.cr);
      end
    end
  end

  // One cycle: drive inputs, push the outputs expected after the next edge.
  task automatic cyc(input logic r, input logic ss, input logic lp,
                     input logic cl, input logic co,
                     input logic [1:0] st, input logic tk,
                     input logic hd, input logic cr);
    exp_t e;
    reset      = r;
    btn_ss     = ss;
    btn_lap    = lp;
    btn_clr    = cl;
    chain_cout = co;
    e.st = st; e.tk = tk; e.hd = hd; e.cr = cr;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Plain cycle with no button activity.
  task automatic nop(input logic [1:0] st, input logic tk,
                     input logic hd);
    cyc(0, 0, 0, 0, 0, st, tk, hd, 0);
  endtask

  initial begin
    reset = 1'b1; btn_ss = 0; btn_lap = 0; btn_clr = 0; chain_cout = 0;
    @(negedge clk);

    // Reset held two cycles, then the chain_reset tail.
    cyc(1, 0, 0, 0, 0, 2'b00, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 2'b00, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    // Lap and clear ignored in IDLE.
    cyc(0, 0, 1, 0, 0, 2'b00, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 2'b00, 0, 0, 0);

    // Start: ticks at +4, +8, +12.
    cyc(0, 1, 0, 0, 0, 2'b01, 0, 0, 0);
    for (int k = 1; k <= 12; k++) nop(2'b01, (k % 4) == 0, 0);

    // Pause with prescaler frozen at 2, resume gives tick 2 cycles later.
    nop(2'b01, 0, 0);
    cyc(0, 1, 0, 0, 0, 2'b10, 0, 0, 0);
    for (int k = 0; k < 10; k++) nop(2'b10, 0, 0);
    cyc(0, 1, 0, 0, 0, 2'b01, 0, 0, 0);
    nop(2'b01, 0, 0);
    nop(2'b01, 1, 0);

    // Lap: hold on, ticks continue; release coincides with a wrap.
    cyc(0, 0, 1, 0, 0, 2'b11, 0, 1, 0);
    nop(2'b11, 0, 1);
    nop(2'b11, 0, 1);
    nop(2'b11, 1, 1);
    nop(2'b11, 0, 1);
    nop(2'b11, 0, 1);
    nop(2'b11, 0, 1);
    cyc(0, 0, 1, 0, 0, 2'b01, 1, 0, 0);

    // Clear ignored in RUN; pause; ss+clr in PAUSE clears.
    cyc(0, 0, 0, 1, 0, 2'b01, 0, 0, 0);
    nop(2'b01, 0, 0);
    cyc(0, 1, 0, 0, 0, 2'b10, 0, 0, 0);
    nop(2'b10, 0, 0);
    cyc(0, 1, 0, 1, 0, 2'b00, 0, 0, 1);
    nop(2'b00, 0, 0);
    // Restart proves the prescaler was cleared: tick at +4.
    cyc(0, 1, 0, 0, 0, 2'b01, 0, 0, 0);
    nop(2'b01, 0, 0);
    nop(2'b01, 0, 0);
    nop(2'b01, 0, 0);
    nop(2'b01, 1, 0);

    // Reset mid-LAP just before a wrap discards the tick.
    cyc(0, 0, 1, 0, 0, 2'b11, 0, 1, 0);
    nop(2'b11, 0, 1);
    nop(2'b11, 0, 1);
    cyc(1, 0, 0, 0, 0, 2'b00, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
    nop(2'b00, 0, 0);

    // ss beats lap in RUN; then clear from PAUSE.
    cyc(0, 1, 0, 0, 0, 2'b01, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 2'b10, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 2'b00, 0, 0, 1);
    nop(2'b00, 0, 0);

    // Chain overflow during RUN.
    cyc(0, 1, 0, 0, 0, 2'b01, 0, 0, 0);
    nop(2'b01, 0, 0);
`ifdef STOPWATCH_AUTOSTOP_EN
    cyc(0, 0, 0, 0, 1, 2'b10, 0, 0, 0);
    for (int k = 0; k < 6; k++) nop(2'b10, 0, 0);
`else
    cyc(0, 0, 0, 0, 1, 2'b01, 0, 0, 0);
    nop(2'b01, 0, 0);
    nop(2'b01, 1, 0);
    nop(2'b01, 0, 0);
    nop(2'b01, 0, 0);
    nop(2'b01, 0, 0);
    nop(2'b01, 1, 0);
`endif

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got=%0d left want=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
